// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared size/extension codes and FSM states for the data-memory responder
package dmem_responder_pkg;

    // Access size codes carried on req_size; 2'b11 is not a legal size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Load extension codes carried on req_sext; 2'b11 behaves as SEXT_NONE.
    localparam logic [1:0] SEXT_NONE = 2'b00;
    localparam logic [1:0] SEXT_B    = 2'b01;
    localparam logic [1:0] SEXT_H    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane strobe, store replication, load alignment/extension
//
// Ports:
//   i_size      access size code
//   i_sext      load extension code
//   i_addr_lo   byte offset within the word (addr[1:0])
//   i_word      32-bit word read from the backing store
//   i_wdata     LSB-justified store data
//   o_strb      byte write strobe
//   o_wdata     store data replicated onto every lane
//   o_rdata     aligned and extended load result
//   o_misalign  half on odd byte, or word not on a word boundary
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_sext,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_strb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted  = i_word >> {i_addr_lo, 3'b000};
        o_strb     = 4'b0000;
        o_wdata    = 32'h0;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_strb  = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_sext == SEXT_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                             : {24'h0, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_strb     = 4'b0011 << i_addr_lo;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = (i_sext == SEXT_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                                : {16'h0, w_shifted[15:0]};
                o_misalign = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_strb     = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_word;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_strb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder for the LSU load/store channel
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_wen, req_addr, req_size,
//   req_sext, req_wdata               request payload
//   resp_valid/resp_ready             response handshake
//   resp_rdata, resp_err              response payload
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_sext,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [1:0]  r_sext;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_in_idle;
    logic        w_a_wen;
    logic [31:0] w_a_addr;
    logic [1:0]  w_a_size;
    logic [1:0]  w_a_sext;
    logic [31:0] w_a_wdata;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic        w_oor;
    logic [31:0] w_word;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_ext;
    logic        w_misalign;
    logic        w_err;
    logic [31:0] w_rdata;
    logic        w_do_access;
    logic        w_do_write;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_accept  = w_in_idle && req_valid && r_req_ready;

    // With LATENCY==1 the access happens on the accepting edge, so the
    // request fields come straight from the inputs rather than the latches.
    assign w_a_wen   = w_in_idle ? req_wen   : r_wen;
    assign w_a_addr  = w_in_idle ? req_addr  : r_addr;
    assign w_a_size  = w_in_idle ? req_size  : r_size;
    assign w_a_sext  = w_in_idle ? req_sext  : r_sext;
    assign w_a_wdata = w_in_idle ? req_wdata : r_wdata;

    assign w_off  = w_a_addr - BASE_ADDR;
    assign w_oor  = (w_a_addr < BASE_ADDR) || (w_off[31:2] >= 30'(DEPTH));
    assign w_idx  = w_off[AW+1:2];
    assign w_word = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size     (w_a_size),
        .i_sext     (w_a_sext),
        .i_addr_lo  (w_a_addr[1:0]),
        .i_word     (w_word),
        .i_wdata    (w_a_wdata),
        .o_strb     (w_strb),
        .o_wdata    (w_wdata_rep),
        .o_rdata    (w_ext),
        .o_misalign (w_misalign)
    );

    assign w_err   = w_oor || w_misalign || (w_a_size == SZ_ILL);
    assign w_rdata = (w_err || w_a_wen) ? 32'h0 : w_ext;

    // The access edge is the last WAIT edge (counter reaching zero), or the
    // accept edge itself for single-cycle latency. rst_n gates the write so an
    // in-flight store is dropped while reset is asserted.
    assign w_do_access = rst_n && ((w_accept && (LATENCY == 1)) ||
                                   ((r_state == ST_WAIT) && (r_cnt == 4'd1)));
    assign w_do_write  = w_do_access && w_a_wen && !w_err;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_wen        <= 1'b0;
            r_addr       <= 32'h0;
            r_size       <= SZ_BYTE;
            r_sext       <= SEXT_NONE;
            r_wdata      <= 32'h0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wen       <= req_wen;
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_sext      <= req_sext;
                        r_wdata     <= req_wdata;
                        r_cnt       <= LAT_M1;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_rdata;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rdata;
                        r_resp_err   <= w_err;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
